// File: rtl/mem_arb_pkg.sv
// Shared encodings and constants for the I/D-cache memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W          = 16;
  localparam int WORDS_PER_BLOCK = 8;
  localparam int MEM_LATENCY     = 4;
  localparam logic [2:0]        LAST_WORD  = 3'(WORDS_PER_BLOCK - 1);
  localparam logic [ADDR_W-1:0] BLOCK_MASK = 16'hFFF0;

  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RD_ISSUE = 2'b01,
    RD_DRAIN = 2'b10,
    WRITE    = 2'b11
  } state_t;

  typedef enum logic {
    GRANT_I = 1'b0,
    GRANT_D = 1'b1
  } grant_t;

  // Byte address of word idx within a block of 2-byte words.
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] base,
                                                  input logic [2:0] idx);
    return base + {12'h000, idx, 1'b0};
  endfunction

endpackage

// File: rtl/word_counter.sv
// 3-bit word counter with synchronous clear/enable and a terminal-count flag.
module word_counter
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_clr,
  input  logic       i_en,
  output logic [2:0] o_cnt,
  output logic       o_wrap
);

  logic [2:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= 3'd0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 3'd1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_wrap = (r_cnt == LAST_WORD);

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter serialising I-cache fills, D-cache fills and D-cache
// write-through stores onto the single pipelined memory port.
module mem_arbiter
  import mem_arb_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic              dcache_we,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic [ADDR_W-1:0] dcache_wdata,
  input  logic              mem_data_valid,
  input  logic [ADDR_W-1:0] mem_data_in,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [ADDR_W-1:0] mem_wdata,
  output logic              icache_grant,
  output logic              dcache_grant,
  output logic [ADDR_W-1:0] fill_data,
  output logic [2:0]        fill_word,
  output logic              icache_fill_valid,
  output logic              dcache_fill_valid,
  output logic              icache_done,
  output logic              dcache_done,
  output logic              busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  grant_t            r_grant;
  grant_t            r_last_grant;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_st_addr;
  logic [ADDR_W-1:0] r_st_data;

  logic [2:0] w_issue_cnt;
  logic [2:0] w_recv_cnt;
  logic       w_issue_wrap;
  logic       w_recv_wrap;
  logic       w_idle;
  logic       w_reading;
  logic       w_accept;
  logic       w_last_word;
  logic       w_start;
  logic       w_tie;
  logic       w_pick_d;

  assign w_idle      = (r_state == IDLE);
  assign w_reading   = (r_state == RD_ISSUE) || (r_state == RD_DRAIN);
  assign w_accept    = w_reading && mem_data_valid;
  assign w_last_word = w_accept && w_recv_wrap;
  assign w_tie       = icache_req && dcache_req;
  assign w_start     = w_idle && (icache_req || dcache_req);
  // On a tie the D-cache wins unless it was the last tie winner.
  assign w_pick_d    = dcache_req && (!icache_req || (r_last_grant == GRANT_I));

  word_counter u_issue_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_idle),
    .i_en   (r_state == RD_ISSUE),
    .o_cnt  (w_issue_cnt),
    .o_wrap (w_issue_wrap)
  );

  word_counter u_recv_cnt (
    .clk    (clk),
    .rst    (rst),
    .i_clr  (w_idle),
    .i_en   (w_accept),
    .o_cnt  (w_recv_cnt),
    .o_wrap (w_recv_wrap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_grant      <= GRANT_I;
      r_last_grant <= GRANT_I;
      r_base       <= 16'h0000;
      r_st_addr    <= 16'h0000;
      r_st_data    <= 16'h0000;
    end else begin
      r_state <= w_state_nxt;
      if (w_start) begin
        r_grant   <= w_pick_d ? GRANT_D : GRANT_I;
        r_base    <= (w_pick_d ? dcache_addr : icache_addr) & BLOCK_MASK;
        r_st_addr <= dcache_addr;
        r_st_data <= dcache_wdata;
        if (w_tie) begin
          r_last_grant <= w_pick_d ? GRANT_D : GRANT_I;
        end
      end
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    mem_en            = 1'b0;
    mem_wr            = 1'b0;
    mem_addr          = 16'h0000;
    mem_wdata         = 16'h0000;
    icache_grant      = 1'b0;
    dcache_grant      = 1'b0;
    fill_data         = 16'h0000;
    fill_word         = 3'd0;
    icache_fill_valid = 1'b0;
    dcache_fill_valid = 1'b0;
    icache_done       = 1'b0;
    dcache_done       = 1'b0;
    busy              = !w_idle;

    if (!w_idle) begin
      icache_grant = (r_grant == GRANT_I);
      dcache_grant = (r_grant == GRANT_D);
    end else begin
      icache_grant = 1'b0;
      dcache_grant = 1'b0;
    end

    case (r_state)
      IDLE: begin
        if (w_start) begin
          w_state_nxt = (w_pick_d && dcache_we) ? WRITE : RD_ISSUE;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD_ISSUE: begin
        mem_en   = 1'b1;
        mem_addr = word_addr(r_base, w_issue_cnt);
        if (w_last_word) begin
          w_state_nxt = IDLE;
        end else if (w_issue_wrap) begin
          w_state_nxt = RD_DRAIN;
        end else begin
          w_state_nxt = RD_ISSUE;
        end
      end
      RD_DRAIN: begin
        if (w_last_word) begin
          w_state_nxt = IDLE;
        end else begin
          w_state_nxt = RD_DRAIN;
        end
      end
      WRITE: begin
        mem_en      = 1'b1;
        mem_wr      = 1'b1;
        mem_addr    = r_st_addr;
        mem_wdata   = r_st_data;
        dcache_done = 1'b1;
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    // Returned words are steered to whichever cache owns the current fill.
    if (w_accept) begin
      fill_data         = mem_data_in;
      fill_word         = w_recv_cnt;
      icache_fill_valid = (r_grant == GRANT_I);
      dcache_fill_valid = (r_grant == GRANT_D);
      icache_done       = w_recv_wrap && (r_grant == GRANT_I);
      dcache_done       = w_recv_wrap && (r_grant == GRANT_D);
    end else begin
      fill_data = 16'h0000;
      fill_word = 3'd0;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push per-cycle expected
// outputs; a negedge monitor pops and compares whenever the arbiter is active.
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        icache_req, dcache_req, dcache_we;
  logic [15:0] icache_addr, dcache_addr, dcache_wdata;
  logic        mem_data_valid;
  logic [15:0] mem_data_in;
  logic        mem_en, mem_wr;
  logic [15:0] mem_addr, mem_wdata, fill_data;
  logic        icache_grant, dcache_grant;
  logic [2:0]  fill_word;
  logic        icache_fill_valid, dcache_fill_valid, icache_done, dcache_done, busy;

  mem_arbiter dut (
    .clk(clk), .rst(rst),
    .icache_req(icache_req), .icache_addr(icache_addr),
    .dcache_req(dcache_req), .dcache_we(dcache_we),
    .dcache_addr(dcache_addr), .dcache_wdata(dcache_wdata),
    .mem_data_valid(mem_data_valid), .mem_data_in(mem_data_in),
    .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .icache_grant(icache_grant), .dcache_grant(dcache_grant),
    .fill_data(fill_data), .fill_word(fill_word),
    .icache_fill_valid(icache_fill_valid), .dcache_fill_valid(dcache_fill_valid),
    .icache_done(icache_done), .dcache_done(dcache_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        mem_en;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        ig;
    logic        dg;
    logic [15:0] fill_data;
    logic [2:0]  fill_word;
    logic        ifv;
    logic        dfv;
    logic        idone;
    logic        ddone;
    logic        busy;
  } outs_t;

  typedef struct { int cyc; outs_t o; } exp_t;
  typedef struct { logic [15:0] a; int due; } rd_t;

  exp_t exp_q[$];
  rd_t  rq[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   sp = 1;
  int   next_ok = 0;
  bit   noise = 1'b0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic outs_t cur();
    outs_t o;
    o.mem_en = mem_en;     o.mem_wr = mem_wr;
    o.mem_addr = mem_addr; o.mem_wdata = mem_wdata;
    o.ig = icache_grant;   o.dg = dcache_grant;
    o.fill_data = fill_data; o.fill_word = fill_word;
    o.ifv = icache_fill_valid; o.dfv = dcache_fill_valid;
    o.idone = icache_done; o.ddone = dcache_done; o.busy = busy;
    return o;
  endfunction

  // Fields with no meaning this cycle are zeroed before comparison.
  function automatic outs_t norm(input outs_t o);
    outs_t r;
    r = o;
    if (!r.mem_en) r.mem_addr = 16'h0000;
    if (!r.mem_wr) r.mem_wdata = 16'h0000;
    if (!(r.ifv || r.dfv)) begin
      r.fill_data = 16'h0000;
      r.fill_word = 3'd0;
    end
    return r;
  endfunction

  // Expected cycles T+1.. of a fill granted at edge T; valid k lands at T+5+k*s.
  task automatic push_fill(input int t, input bit is_d, input logic [15:0] addr,
                           input int s, input int upto);
    logic [15:0] base;
    int last, n, w;
    exp_t e;
    base = addr & 16'hFFF0;
    last = 5 + 7 * s;
    n = (upto > 0) ? upto : last;
    for (int i = 1; i <= n; i++) begin
      e.cyc = t + i;
      e.o = '0;
      e.o.busy = 1'b1;
      e.o.ig = !is_d;
      e.o.dg = is_d;
      if (i <= 8) begin
        e.o.mem_en = 1'b1;
        e.o.mem_addr = base + 16'(2 * (i - 1));
      end
      if (i >= 5 && ((i - 5) % s) == 0) begin
        w = (i - 5) / s;
        e.o.fill_data = (base + 16'(2 * w)) ^ 16'h5A5A;
        e.o.fill_word = 3'(w);
        if (is_d) e.o.dfv = 1'b1; else e.o.ifv = 1'b1;
      end
      if (i == last) begin
        if (is_d) e.o.ddone = 1'b1; else e.o.idone = 1'b1;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Memory model: read data = addr ^ 5A5A, 4-cycle latency, valids spaced by sp.
  initial begin
    mem_data_valid = 1'b0;
    mem_data_in = 16'h0000;
    forever begin
      @(negedge clk);
      if (rst === 1'b1) rq.delete();
      else if (mem_en === 1'b1 && mem_wr === 1'b0) rq.push_back('{a: mem_addr, due: cyc + 4});
      @(posedge clk);
      #1;
      mem_data_valid = 1'b0;
      mem_data_in = 16'h0000;
      if (rq.size() > 0) begin
        if (rq[0].due <= cyc && cyc >= next_ok) begin
          mem_data_valid = 1'b1;
          mem_data_in = rq[0].a ^ 16'h5A5A;
          next_ok = cyc + sp;
          void'(rq.pop_front());
        end
      end else if (noise) begin
        mem_data_valid = 1'($urandom_range(0, 1));
        mem_data_in = 16'($urandom);
      end
    end
  end

  outs_t m_act;
  exp_t  m_e;
  bit    m_ev;
  always @(negedge clk) begin
    if (mon_en) begin
      m_act = cur();
      m_ev = (m_act.busy | m_act.mem_en | m_act.ifv | m_act.dfv | m_act.idone | m_act.ddone) === 1'b1;
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_cyc%0d: got no output expected %h", exp_q[0].cyc, exp_q[0].o);
        void'(exp_q.pop_front());
      end
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        m_e = exp_q.pop_front();
        chk($sformatf("cyc%0d", cyc), 64'(norm(m_act)), 64'(m_e.o));
      end else if (m_ev) begin
        chk($sformatf("unexpected_cyc%0d", cyc), 64'(norm(m_act)), 64'h0);
      end
    end
  end

  int k;
  initial begin
    rst = 1'b1;
    icache_req = 1'b0; icache_addr = 16'h0000;
    dcache_req = 1'b0; dcache_we = 1'b0;
    dcache_addr = 16'h0000; dcache_wdata = 16'h0000;
    step(3);
    rst = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_outputs", 64'(cur()), 64'h0);

    // Idle with random memory valids: nothing may move.
    noise = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      @(negedge clk);
      chk($sformatf("idle_noise%0d", i), 64'(cur()), 64'h0);
    end
    noise = 1'b0;
    step(2);

    // I-cache fill, unaligned miss address.
    k = cyc;
    icache_req = 1'b1; icache_addr = 16'h1233;
    push_fill(k, 1'b0, 16'h1233, 1, 0);
    step(13);
    icache_req = 1'b0;
    step(2);

    // Tie after reset: D first, then I at T+14.
    k = cyc;
    icache_req = 1'b1; icache_addr = 16'h3010;
    dcache_req = 1'b1; dcache_we = 1'b0; dcache_addr = 16'h2008;
    push_fill(k, 1'b1, 16'h2008, 1, 0);
    push_fill(k + 13, 1'b0, 16'h3010, 1, 0);
    step(13);
    dcache_req = 1'b0;
    step(13);
    icache_req = 1'b0;
    step(2);

    // Repeated tie: D won the last tie, so I wins now.
    k = cyc;
    icache_req = 1'b1; icache_addr = 16'h7777;
    dcache_req = 1'b1; dcache_we = 1'b0; dcache_addr = 16'h8880;
    push_fill(k, 1'b0, 16'h7777, 1, 0);
    push_fill(k + 13, 1'b1, 16'h8880, 1, 0);
    step(13);
    icache_req = 1'b0;
    step(13);
    dcache_req = 1'b0;
    step(2);

    // D-cache single-word store.
    k = cyc;
    dcache_req = 1'b1; dcache_we = 1'b1; dcache_addr = 16'h4567; dcache_wdata = 16'hBEEF;
    exp_q.push_back('{cyc: k + 1, o: '{mem_en: 1'b1, mem_wr: 1'b1, mem_addr: 16'h4567,
                     mem_wdata: 16'hBEEF, ig: 1'b0, dg: 1'b1, fill_data: 16'h0000,
                     fill_word: 3'd0, ifv: 1'b0, dfv: 1'b0, idone: 1'b0, ddone: 1'b1,
                     busy: 1'b1}});
    step(2);
    dcache_req = 1'b0; dcache_we = 1'b0;
    @(negedge clk);
    chk("store_back_idle", 64'(busy), 64'h0);
    step(2);

    // Slow memory at top of address space; request dropped mid-fill.
    sp = 4;
    k = cyc;
    icache_req = 1'b1; icache_addr = 16'hFFF3;
    push_fill(k, 1'b0, 16'hFFF3, 4, 0);
    step(10);
    icache_req = 1'b0;
    step(26);
    sp = 1;

    // Reset in the middle of a fill, then a fresh request.
    k = cyc;
    icache_req = 1'b1; icache_addr = 16'h5550;
    push_fill(k, 1'b0, 16'h5550, 1, 6);
    step(6);
    rst = 1'b1;
    icache_req = 1'b0;
    step(1);
    rst = 1'b0;
    @(negedge clk);
    chk("mid_reset_outputs", 64'(cur()), 64'h0);
    k = cyc;
    icache_req = 1'b1; icache_addr = 16'h0ABC;
    push_fill(k, 1'b0, 16'h0ABC, 1, 0);
    step(13);
    icache_req = 1'b0;
    step(4);

    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
